// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared widths, types and state encoding for the 1-to-4 stream demux
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0]  ch_sel_t;
  typedef logic [NUM_CH-1:0] ch_mask_t;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HELD  = 1'b1;

endpackage

// File: rtl/decoder_2x4.sv
// rtl/decoder_2x4.sv - gate-level 2-to-4 one-hot decoder with enable
import demux_pkg::*;

module decoder_2x4 (
  input  logic     en,
  input  ch_sel_t  sel,
  output ch_mask_t dec
);

  logic sel0_n;
  logic sel1_n;

  assign sel0_n = ~sel[0];
  assign sel1_n = ~sel[1];

  assign dec[0] = en & sel1_n & sel0_n;
  assign dec[1] = en & sel1_n & sel[0];
  assign dec[2] = en & sel[1] & sel0_n;
  assign dec[3] = en & sel[1] & sel[0];

endmodule

// File: rtl/demux_1x4_reg.sv
// rtl/demux_1x4_reg.sv - registered 1-to-4 stream demux with a one-entry holding register
import demux_pkg::*;

module demux_1x4_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  ch_sel_t          in_select_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output ch_mask_t         out_valid_o,
  input  ch_mask_t         out_ready_i
);

  logic [0:0]       state;
  logic [WIDTH-1:0] data_q;
  ch_sel_t          dest_q;
  logic             full;
  logic             in_fire;
  logic             out_fire;

  assign full     = (state == ST_HELD);
  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = full && out_ready_i[dest_q];

  // Only the held target's ready matters; in_valid_i never feeds back into in_ready_o.
  always_comb begin
    in_ready_o = 1'b0;
    if (!full || out_ready_i[dest_q]) begin
      in_ready_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= ST_EMPTY;
      data_q <= '0;
      dest_q <= '0;
    end else if (in_fire) begin
      state  <= ST_HELD;
      data_q <= in_data_i;
      dest_q <= in_select_i;
    end else if (out_fire) begin
      state  <= ST_EMPTY;
    end
  end

  assign out_data_o = data_q;

  decoder_2x4 u_valid_dec (
    .en  (full),
    .sel (dest_q),
    .dec (out_valid_o)
  );

endmodule
